// File: rtl/mult_hilo_sequencer.sv
// HI/LO owner for the MIPS EX stage: 32-iteration shift-add MULT/MULTU (plus MADD/MADDU
// when MULT_HILO_MADD_EN is defined) and single-cycle MFHI/MFLO reads.
module mult_hilo_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        illegal
);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MADDU = 6'b011101;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINAL} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_mcand, r_mplier, r_phi;
  logic        r_neg;
  logic [31:0] r_hi, r_lo, r_result;
  logic        r_done, r_rvalid, r_illegal;
`ifdef MULT_HILO_MADD_EN
  logic        r_madd;
`endif

  logic        w_accept, w_is_mul, w_is_read, w_signed;
  logic [31:0] w_rs_abs, w_rt_abs, w_addend;
  logic [32:0] w_sum;
  logic [63:0] w_prod, w_p, w_final;

  assign w_accept  = req && !busy && !cancel;
  assign w_is_read = (op == OP_MFHI) || (op == OP_MFLO);
`ifdef MULT_HILO_MADD_EN
  assign w_is_mul  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
  assign w_is_mul  = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign w_signed  = !op[0];
  assign w_rs_abs  = (w_signed && rs_val[31]) ? -rs_val : rs_val;
  assign w_rt_abs  = (w_signed && rt_val[31]) ? -rt_val : rt_val;

  // Carry out of the upper-half add shifts back in as the new product MSB.
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = {1'b0, r_phi} + {1'b0, w_addend};
  assign w_prod    = {r_phi, r_mplier};
  assign w_p       = r_neg ? -w_prod : w_prod;
`ifdef MULT_HILO_MADD_EN
  assign w_final   = r_madd ? ({r_hi, r_lo} + w_p) : w_p;
`else
  assign w_final   = w_p;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_next = S_CALC;
      S_CALC: begin
        if (cancel)                       w_next = S_IDLE;
        else if (r_cnt == 5'(ITER - 1))   w_next = S_FINAL;
      end
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_phi     <= '0;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
`ifdef MULT_HILO_MADD_EN
      r_madd    <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_mcand  <= w_rs_abs;
              r_mplier <= w_rt_abs;
              r_phi    <= '0;
              r_cnt    <= '0;
              r_neg    <= w_signed && (rs_val[31] ^ rt_val[31]);
`ifdef MULT_HILO_MADD_EN
              r_madd   <= op[2];
`endif
            end else if (w_is_read) begin
              r_result <= (op == OP_MFHI) ? r_hi : r_lo;
              r_rvalid <= 1'b1;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (!cancel) begin
            r_phi    <= w_sum[32:1];
            r_mplier <= {w_sum[0], r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
          end
        end
        S_FINAL: begin
          if (!cancel) begin
            {r_hi, r_lo} <= w_final;
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign stall        = req && busy && !cancel;
  assign done         = r_done;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign result       = r_result;
  assign result_valid = r_rvalid;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed bench for mult_hilo_sequencer; honours MULT_HILO_MADD_EN for the MADD case.
module tb_mult_hilo_sequencer;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_MADD  = 6'b011100;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;

  logic        clk = 1'b0;
  logic        rst_n, req, cancel;
  logic [5:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall, busy, done, result_valid, illegal;
  logic [31:0] hi, lo, result;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mult_hilo_sequencer #(.ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .result(result), .result_valid(result_valid), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    req = 1'b1; op = o; rs_val = a; rt_val = b;
  endtask

  task automatic run_mul(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int unsigned n;
    present(o, a, b);
    tick();
    req = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int unsigned n;
    int unsigned seen_done;
    rst_n = 1'b0; req = 1'b0; cancel = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", {60'd0, busy, done, result_valid, illegal}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    tick();

    run_mul("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_mul("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_mul("mult_ff", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);

    // MULT 7x6 with MFHI held from cycle 5 until busy drops
    present(OP_MULT, 32'd7, 32'd6);
    tick();
    req = 1'b0;
    repeat (4) tick();
    present(OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("stall_hi", 64'(stall), 64'd1);
    n = 0;
    while (stall && n < 60) begin
      tick();
      n++;
    end
    chk("stall_len", 64'(n), 64'd29);
    chk("stall_end_done", 64'(done), 64'd1);
    tick();
    chk("mfhi_valid", 64'(result_valid), 64'd1);
    chk("mfhi_result", 64'(result), 64'd0);
    op = OP_MFLO;
    tick();
    chk("mflo_valid", 64'(result_valid), 64'd1);
    chk("mflo_result", 64'(result), 64'd42);
    req = 1'b0;
    tick();
    chk("rvalid_pulse", 64'(result_valid), 64'd0);

    run_mul("mult_2x3", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6);
`ifdef MULT_HILO_MADD_EN
    run_mul("madd_4xm1", OP_MADD, 32'd4, 32'hFFFFFFFF, 32'd0, 32'd2);
`else
    present(OP_MADD, 32'd4, 32'hFFFFFFFF);
    #1;
    chk("madd_nostall", 64'(stall), 64'd0);
    tick();
    req = 1'b0;
    chk("madd_illegal", 64'(illegal), 64'd1);
    chk("madd_busy", 64'(busy), 64'd0);
    chk("madd_lo", 64'(lo), 64'd6);
    tick();
    chk("illegal_pulse", 64'(illegal), 64'd0);
`endif

    present(6'b111111, 32'd1, 32'd1);
    tick();
    req = 1'b0;
    chk("bad_op_illegal", 64'(illegal), 64'd1);
    chk("bad_op_lo", 64'(lo), 64'(`ifdef MULT_HILO_MADD_EN 2 `else 6 `endif));

    // cancel at cycle 10 of MULT 9x9
    present(OP_MULT, 32'd9, 32'd9);
    tick();
    req = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    seen_done = 0;
    repeat (30) begin
      tick();
      if (done) seen_done++;
    end
    chk("cancel_no_done", 64'(seen_done), 64'd0);
    chk("cancel_hilo", {hi, lo}, `ifdef MULT_HILO_MADD_EN 64'd2 `else 64'd6 `endif);

    present(OP_MULT, 32'd3, 32'd3);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    req = 1'b0;
    chk("cancel_idle_drop", 64'(busy), 64'd0);

    // reset at cycle 20 of MULT 5x5
    present(OP_MULT, 32'd5, 32'd5);
    tick();
    req = 1'b0;
    repeat (19) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_flags", {59'd0, busy, done, result_valid, illegal, stall}, 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    present(OP_MFLO, 32'd0, 32'd0);
    tick();
    req = 1'b0;
    chk("post_rst_mflo_valid", 64'(result_valid), 64'd1);
    chk("post_rst_mflo", 64'(result), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
